// File: rtl/fetch_sequencer_if.sv
// Fetch-stage bus bundle: decode-side controls, the ROM port and the IF/ID outputs.
//   slave  : the fetch sequencer (consumes *_i, produces *_o)
//   master : the environment (pipeline control, ROM model, decode stage)
// Signals:
//   stall_i       hold PC/nPC and IF/ID contents
//   flush_i       squash the instruction being written into IF/ID
//   br_taken_i    branch resolved taken (one-cycle pulse)
//   br_target_i   branch target byte address
//   imem_data_i   ROM word for imem_addr_o (combinational read)
//   imem_addr_o   ROM byte address (the PC register)
//   ifid_instr_o  registered instruction
//   ifid_pc_o     address of ifid_instr_o
//   ifid_valid_o  ifid_instr_o is live
//   halted_o      fetch stopped
//   fetch_count_o valid instructions delivered, saturating
interface fetch_sequencer_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              stall_i;
    logic              flush_i;
    logic              br_taken_i;
    logic [ADDR_W-1:0] br_target_i;
    logic [31:0]       imem_data_i;
    logic [ADDR_W-1:0] imem_addr_o;
    logic [31:0]       ifid_instr_o;
    logic [ADDR_W-1:0] ifid_pc_o;
    logic              ifid_valid_o;
    logic              halted_o;
    logic [15:0]       fetch_count_o;

    modport slave (
        input  stall_i, flush_i, br_taken_i, br_target_i, imem_data_i,
        output imem_addr_o, ifid_instr_o, ifid_pc_o, ifid_valid_o, halted_o, fetch_count_o
    );

    modport master (
        output stall_i, flush_i, br_taken_i, br_target_i, imem_data_i,
        input  imem_addr_o, ifid_instr_o, ifid_pc_o, ifid_valid_o, halted_o, fetch_count_o
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Program-counter controller for a byte-addressed, big-endian instruction ROM.
// Holds a PC/nPC pair with delayed-branch semantics (exactly one delay slot),
// drives the ROM address from the PC register and registers each fetched word
// into IF/ID. Supports stall (with a pending-branch latch), squash, and halt on
// an all-zero instruction word.
// Ports:
//   clk   rising-edge clock
//   rst_n asynchronous active-low reset
//   bus   fetch_sequencer_if.slave (controls, ROM port, IF/ID outputs)
module fetch_sequencer #(
    parameter int unsigned            ADDR_W       = 8,
    parameter logic [ADDR_W-1:0]      RESET_PC     = '0,
    parameter bit                     HALT_ON_ZERO = 1'b1
) (
    input logic               clk,
    input logic               rst_n,
    fetch_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {StBoot, StRun, StHalt} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] npc_q;
    logic              pend_valid_q;
    logic [ADDR_W-1:0] pend_target_q;
    logic [31:0]       ifid_instr_q;
    logic [ADDR_W-1:0] ifid_pc_q;
    logic              ifid_valid_q;
    logic              halted_q;
    logic [15:0]       fetch_count_q;

    logic [ADDR_W-1:0] br_target_aligned;
    logic [ADDR_W-1:0] npc_d;
    logic              halt_hit;

    always_comb begin
        br_target_aligned = {bus.br_target_i[ADDR_W-1:2], 2'b00};
        // A live branch wins over one latched during a stall.
        if (bus.br_taken_i) begin
            npc_d = br_target_aligned;
        end else if (pend_valid_q) begin
            npc_d = pend_target_q;
        end else begin
            npc_d = npc_q + ADDR_W'(4);
        end
        halt_hit = HALT_ON_ZERO && !bus.flush_i && (bus.imem_data_i == 32'h0000_0000);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StBoot;
            pc_q          <= RESET_PC;
            npc_q         <= RESET_PC + ADDR_W'(4);
            pend_valid_q  <= 1'b0;
            pend_target_q <= '0;
            ifid_instr_q  <= '0;
            ifid_pc_q     <= '0;
            ifid_valid_q  <= 1'b0;
            halted_q      <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            unique case (state_q)
                StBoot: begin
                    state_q <= StRun;
                end
                StRun: begin
                    if (!bus.stall_i) begin
                        ifid_instr_q <= bus.imem_data_i;
                        ifid_pc_q    <= pc_q;
                        if (halt_hit) begin
                            // Zero word is swallowed; PC/nPC stay put for good.
                            ifid_valid_q <= 1'b0;
                            halted_q     <= 1'b1;
                            state_q      <= StHalt;
                        end else begin
                            ifid_valid_q <= !bus.flush_i;
                            pc_q         <= npc_q;
                            npc_q        <= npc_d;
                            pend_valid_q <= 1'b0;
                            if (!bus.flush_i && fetch_count_q != 16'hFFFF) begin
                                fetch_count_q <= fetch_count_q + 16'd1;
                            end
                        end
                    end else begin
                        if (bus.flush_i) begin
                            ifid_valid_q <= 1'b0;
                        end
                        // Remember a branch resolved during the stall; last one wins.
                        if (bus.br_taken_i) begin
                            pend_valid_q  <= 1'b1;
                            pend_target_q <= br_target_aligned;
                        end
                    end
                end
                StHalt: begin
                    ifid_valid_q <= 1'b0;
                end
                default: begin
                    state_q <= StHalt;
                end
            endcase
        end
    end

    assign bus.imem_addr_o   = pc_q;
    assign bus.ifid_instr_o  = ifid_instr_q;
    assign bus.ifid_pc_o     = ifid_pc_q;
    assign bus.ifid_valid_o  = ifid_valid_q;
    assign bus.halted_o      = halted_q;
    assign bus.fetch_count_o = fetch_count_q;

endmodule
